sphincs_sha256_core_arbiter: RTL

//  Shares one SHA-256 compression core (RTL_crypto_hashblocks_sha256) between NUM_REQ SPHINCS+ hash engines
//  (H_msg, PRF, F/H/T_l tweakable hashes). Each request is one 512-bit block plus a 256-bit chaining value;
//  the response is the 256-bit compressed digest. Round-robin grant; one block in flight at a time.

---
 rtl/sphincs_sha256_pkg.sv | 17 +
 rtl/sphincs_rr_pick.sv | 31 +++
 rtl/sphincs_sha256_core_arbiter.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/sphincs_sha256_pkg.sv
// Shared constants and types for the SPHINCS+ SHA-256 core arbiter.
package sphincs_sha256_pkg;

  localparam int unsigned BLK_W = 512;
  localparam int unsigned DIG_W = 256;

  localparam logic [255:0] SHA256_IV =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT,
    ARB_RESP
  } arb_state_e;

endpackage

// File: rtl/sphincs_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module sphincs_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    idx,
  output logic               any
);

  logic [ID_W-1:0] cand;

  // Scan ptr, ptr+1, ... mod NUM_REQ and keep the first requester found.
  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      cand = ID_W'((32'(ptr) + off) % NUM_REQ);
      if (!any && req[cand]) begin
        any       = 1'b1;
        idx       = cand;
        gnt[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sphincs_sha256_core_arbiter.sv
// Round-robin arbiter sharing one SHA-256 compression core between NUM_REQ
// SPHINCS+ hash engines; one block in flight at a time.
// Optional macro SPHINCS_ARB_LOCK_EN adds req_lock to keep multi-block
// messages of one requester contiguous on the core.
module sphincs_sha256_core_arbiter
  import sphincs_sha256_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [NUM_REQ-1:0]         req_valid,
`ifdef SPHINCS_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]         req_lock,
`endif
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*BLK_W-1:0]   req_msg,
  input  logic [NUM_REQ*DIG_W-1:0]   req_digest,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [DIG_W-1:0]           rsp_digest,
  output logic                       busy,
  output logic [ID_W-1:0]            grant_id,
  output logic                       core_start,
  output logic [BLK_W-1:0]           core_msg,
  output logic [DIG_W-1:0]           core_digest_in,
  input  logic [DIG_W-1:0]           core_digest_out,
  input  logic                       core_valid_out
);

  arb_state_e           state_q, state_d;
  logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]      grant_id_q, grant_id_d;
  logic                 busy_q, busy_d;
  logic                 core_start_q, core_start_d;
  logic [BLK_W-1:0]     core_msg_q, core_msg_d;
  logic [DIG_W-1:0]     core_din_q, core_din_d;
  logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [DIG_W-1:0]     rsp_digest_q, rsp_digest_d;
`ifdef SPHINCS_ARB_LOCK_EN
  logic                 lock_act_q, lock_act_d;
  logic [ID_W-1:0]      lock_id_q, lock_id_d;
`endif

  logic [NUM_REQ-1:0]   eligible;
  logic [NUM_REQ-1:0]   pick_gnt;
  logic [ID_W-1:0]      pick_idx;
  logic                 pick_any;
  logic                 accept;

  // Requesters allowed to compete this cycle (only the lock holder while locked).
  always_comb begin
`ifdef SPHINCS_ARB_LOCK_EN
    eligible = lock_act_q ? (req_valid & (NUM_REQ'(1'b1) << lock_id_q)) : req_valid;
`else
    eligible = req_valid;
`endif
  end

  sphincs_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req (eligible),
    .ptr (rr_ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Acceptance is combinational in IDLE; suppressed while reset is asserted.
  always_comb begin
    accept    = (state_q == ARB_IDLE) && pick_any && !RST;
    req_ready = accept ? pick_gnt : '0;
  end

  // Next-state and next-output computation for the arbiter FSM.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    grant_id_d   = grant_id_q;
    busy_d       = busy_q;
    core_start_d = 1'b0;
    core_msg_d   = core_msg_q;
    core_din_d   = core_din_q;
    rsp_valid_d  = '0;
    rsp_digest_d = rsp_digest_q;
`ifdef SPHINCS_ARB_LOCK_EN
    lock_act_d   = lock_act_q;
    lock_id_d    = lock_id_q;
`endif
    case (state_q)
      ARB_IDLE: begin
        if (accept) begin
          for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (pick_gnt[i]) begin
              core_msg_d = req_msg[i*BLK_W +: BLK_W];
              core_din_d = req_digest[i*DIG_W +: DIG_W];
            end
          end
          grant_id_d   = pick_idx;
          rr_ptr_d     = (pick_idx == ID_W'(NUM_REQ-1)) ? '0 : pick_idx + 1'b1;
          busy_d       = 1'b1;
          core_start_d = 1'b1;
          state_d      = ARB_ISSUE;
`ifdef SPHINCS_ARB_LOCK_EN
          lock_act_d   = req_lock[pick_idx];
          lock_id_d    = pick_idx;
`endif
        end
      end
      ARB_ISSUE: state_d = ARB_WAIT;
      ARB_WAIT: begin
        if (core_valid_out) begin
          rsp_digest_d = core_digest_out;
          rsp_valid_d  = NUM_REQ'(1'b1) << grant_id_q;
          state_d      = ARB_RESP;
        end
      end
      ARB_RESP: begin
        busy_d  = 1'b0;
        state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // FSM state and registered outputs; synchronous active-high reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= ARB_IDLE;
      rr_ptr_q     <= '0;
      grant_id_q   <= '0;
      busy_q       <= 1'b0;
      core_start_q <= 1'b0;
      core_msg_q   <= '0;
      core_din_q   <= '0;
      rsp_valid_q  <= '0;
      rsp_digest_q <= '0;
`ifdef SPHINCS_ARB_LOCK_EN
      lock_act_q   <= 1'b0;
      lock_id_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_id_q   <= grant_id_d;
      busy_q       <= busy_d;
      core_start_q <= core_start_d;
      core_msg_q   <= core_msg_d;
      core_din_q   <= core_din_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_digest_q <= rsp_digest_d;
`ifdef SPHINCS_ARB_LOCK_EN
      lock_act_q   <= lock_act_d;
      lock_id_q    <= lock_id_d;
`endif
    end
  end

  assign busy           = busy_q;
  assign grant_id       = grant_id_q;
  assign core_start     = core_start_q;
  assign core_msg       = core_msg_q;
  assign core_digest_in = core_din_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_digest     = rsp_digest_q;

endmodule
